// File: rtl/pwm_pkg.sv
// Shared defaults for the PWM generator and its dead-time helper.
package pwm_pkg;

    localparam int unsigned PWM_R_DEF    = 8;
    localparam int unsigned PWM_DEAD_DEF = 2;

endpackage

// File: rtl/pwm_deadtime.sv
// Rising-edge delay: o_level follows i_level but rises DEAD clocks late.
// A high pulse of DEAD clocks or fewer never reaches the output.
module pwm_deadtime #(
    parameter int unsigned W    = 8,
    parameter int unsigned DEAD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_level
);

    localparam logic [W-1:0] DeadW = W'(DEAD);

    logic [W-1:0] r_run;
    logic         r_en;

    // r_run counts clocks i_level has been high, saturating at DEAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= '0;
            r_en  <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (!i_level) begin
                r_run <= '0;
            end else if (r_run != DeadW) begin
                r_run <= r_run + W'(1);
            end
        end
    end

    // r_en keeps the output low until the first clock after reset release.
    assign o_level = r_en & i_level & (r_run == DeadW);

endmodule

// File: rtl/pwm_basic.sv
// Free-running PWM with double-buffered duty, reloaded at each period boundary.
// Define PWM_COMPL_OUT_EN to add dead-time complementary outputs pwm_out_hi/lo.
module pwm_basic
    import pwm_pkg::*;
#(
    parameter int unsigned R = PWM_R_DEF
`ifdef PWM_COMPL_OUT_EN
    ,
    parameter int unsigned DEAD_CYC = PWM_DEAD_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [R-1:0] duty,
    output logic         pwm_out,
    output logic         period_start
`ifdef PWM_COMPL_OUT_EN
    ,
    output logic         pwm_out_hi,
    output logic         pwm_out_lo
`endif
);

    logic [R-1:0] r_cnt;
    logic [R-1:0] r_duty_q;
    logic         r_pwm;
    logic         r_period_start;
    logic         w_wrap;

    assign w_wrap = (r_cnt == {R{1'b1}});

    // Shadow duty loads on the last clock so a period never sees a mid-period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_duty_q       <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + R'(1);
            r_pwm          <= (r_cnt < r_duty_q);
            r_period_start <= (r_cnt == '0);
            if (w_wrap) begin
                r_duty_q <= duty;
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

`ifdef PWM_COMPL_OUT_EN
    logic w_pwm_n;

    assign w_pwm_n = ~r_pwm;

    pwm_deadtime #(
        .W    (R),
        .DEAD (DEAD_CYC)
    ) u_dt_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (r_pwm),
        .o_level (pwm_out_hi)
    );

    pwm_deadtime #(
        .W    (R),
        .DEAD (DEAD_CYC)
    ) u_dt_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (w_pwm_n),
        .o_level (pwm_out_lo)
    );
`endif

endmodule

// File: tb/tb_pwm_basic.sv
// Scoreboard bench for pwm_basic: duty sampled at each period boundary is queued
// and compared against the high-time measured over the following period.
module tb_pwm_basic;
    import pwm_pkg::*;

    localparam int unsigned R      = 8;
    localparam int unsigned Period = 1 << R;
    localparam int unsigned TMax   = Period - 1;

    logic         clk;
    logic         rst_n;
    logic [R-1:0] duty;
    logic         pwm_out;
    logic         period_start;
`ifdef PWM_COMPL_OUT_EN
    localparam int unsigned Dead = PWM_DEAD_DEF;
    logic pwm_out_hi;
    logic pwm_out_lo;
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_per  = 0;
    int unsigned exp_q[$];
    int unsigned tb_cnt = 0;

`ifdef PWM_COMPL_OUT_EN
    pwm_basic #(
        .R        (R),
        .DEAD_CYC (Dead)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pwm_out_hi   (pwm_out_hi),
        .pwm_out_lo   (pwm_out_lo)
    );
`else
    pwm_basic #(
        .R (R)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );
`endif

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference period counter; queues the duty the DUT should latch at the boundary.
    always @(posedge clk) begin
        if (!rst_n) begin
            tb_cnt <= 0;
        end else begin
            if (tb_cnt == TMax) exp_q.push_back(int'(duty));
            tb_cnt <= (tb_cnt + 1) % Period;
        end
    end

    int unsigned mon_hi, mon_len, exp_d;
    bit          mon_in, mon_low, mon_glitch;
`ifdef PWM_COMPL_OUT_EN
    int unsigned mon_phi, mon_plo;
    bit          mon_ovl;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_in = 1'b0;
        end else begin
            if (period_start) begin
                check_eq("ps_phase", tb_cnt, 1);
                if (mon_in) begin
                    n_per++;
                    check_eq("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_d = exp_q.pop_front();
                        check_eq("hi_clocks", mon_hi, exp_d);
                        check_eq("contiguous", mon_glitch, 0);
                        check_eq("period_len", mon_len, Period);
`ifdef PWM_COMPL_OUT_EN
                        check_eq("hi_lo_overlap", mon_ovl, 0);
                        if (exp_d != 0) begin
                            check_eq("hi_dead", mon_phi, (exp_d > Dead) ? exp_d - Dead : 0);
                            check_eq("lo_dead", mon_plo,
                                     ((Period - exp_d) > Dead) ? Period - exp_d - Dead : 0);
                        end
`endif
                    end
                end
                mon_in     = 1'b1;
                mon_hi     = 0;
                mon_len    = 0;
                mon_low    = 1'b0;
                mon_glitch = 1'b0;
`ifdef PWM_COMPL_OUT_EN
                mon_phi = 0;
                mon_plo = 0;
                mon_ovl = 1'b0;
`endif
            end
            if (mon_in) begin
                mon_len++;
                if (pwm_out) begin
                    mon_hi++;
                    if (mon_low) mon_glitch = 1'b1;
                end else begin
                    mon_low = 1'b1;
                end
`ifdef PWM_COMPL_OUT_EN
                if (pwm_out_hi) mon_phi++;
                if (pwm_out_lo) mon_plo++;
                if (pwm_out_hi && pwm_out_lo) mon_ovl = 1'b1;
`endif
            end
        end
    end

    task automatic wait_cnt(input int unsigned c);
        int k = 0;
        while (tb_cnt != c && k < 2 * Period) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        duty  = 8'd10;
        exp_q.push_back(0);
        repeat (3) @(negedge clk);
        check_eq("rst_pwm_out", pwm_out, 0);
        check_eq("rst_period_start", period_start, 0);
`ifdef PWM_COMPL_OUT_EN
        check_eq("rst_hi", pwm_out_hi, 0);
        check_eq("rst_lo", pwm_out_lo, 0);
`endif
        rst_n = 1'b1;

        // First period runs at duty_q=0, then 10.
        repeat (3 * Period) @(negedge clk);

        // Mid-period change only takes effect at the next boundary.
        wait_cnt(100);
        duty = 8'd20;
        repeat (2 * Period) @(negedge clk);

        duty = 8'd0;
        repeat (2 * Period) @(negedge clk);
        duty = 8'd255;
        repeat (2 * Period) @(negedge clk);

        for (int d = 10; d <= 90; d += 10) begin
            duty = 8'(d);
            repeat (100) @(negedge clk);
        end
        repeat (Period) @(negedge clk);

        // Reset mid-period while the output is high.
        wait_cnt(50);
        check_eq("pre_rst_pwm_high", pwm_out, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_pwm", pwm_out, 0);
        check_eq("async_rst_ps", period_start, 0);
        exp_q.delete();
        exp_q.push_back(0);
        repeat (3) @(negedge clk);
        check_eq("held_rst_pwm", pwm_out, 0);
        rst_n = 1'b1;
        repeat (2 * Period + 10) @(negedge clk);

        check_eq("periods_seen", n_per >= 12, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
